// File: rtl/imem_fetch_unit.sv
// Word-organised instruction memory with a 1-cycle registered fetch port, a byte-enabled load port
// and a reset-time sweep that fills every word with INIT_WORD before fetches are accepted.
module imem_fetch_unit #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] INIT_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic [1:0]  fetch_fault,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata,
  input  logic [3:0]  prog_be,
  output logic        init_busy
);

  localparam int          IW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_CAP = 32'(DEPTH_WORDS * 4);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH_WORDS - 1);

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic [31:0]   fetch_data_q, fetch_data_d;
  logic [1:0]    fetch_fault_q, fetch_fault_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic          mem_we;
  logic [IW-1:0] mem_widx;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wbe;

  logic [IW-1:0] fetch_idx;
  logic [IW-1:0] prog_idx;

  assign fetch_idx = fetch_addr[IW+1:2];
  assign prog_idx  = prog_addr[IW+1:2];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    fetch_fault_d = fetch_fault_q;
    mem_we        = 1'b0;
    mem_widx      = cnt_q;
    mem_wdata     = INIT_WORD;
    mem_wbe       = 4'hF;

    case (state_q)
      S_INIT: begin
        // Gating on reset keeps the array untouched while reset is held low.
        mem_we = reset;
        cnt_d  = cnt_q + IW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (prog_we && (prog_addr < BYTE_CAP)) begin
          mem_we    = reset;
          mem_widx  = prog_idx;
          mem_wdata = prog_wdata;
          mem_wbe   = prog_be;
        end
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          if (fetch_addr[1:0] != 2'b00) begin
            fetch_data_d  = INIT_WORD;
            fetch_fault_d = FAULT_ALIGN;
          end else if (fetch_addr >= BYTE_CAP) begin
            fetch_data_d  = INIT_WORD;
            fetch_fault_d = FAULT_RANGE;
          end else begin
            // Array read uses pre-edge contents, giving read-before-write on collisions.
            fetch_data_d  = mem[fetch_idx];
            fetch_fault_d = FAULT_OK;
          end
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= '0;
      fetch_fault_q <= FAULT_OK;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wbe[i]) begin
          mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign fetch_ready = (state_q == S_RUN);
  assign init_busy   = (state_q == S_INIT);
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit (DEPTH_WORDS=64): init sweep, program/fetch, byte enables,
// fault classification, read-before-write collision and reset during fetch stream and sweep.
module tb_imem_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic [1:0]  fetch_fault;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic [3:0]  prog_be;
  logic        init_busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  imem_fetch_unit #(.DEPTH_WORDS(64), .INIT_WORD(32'h00000013)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_fault(fetch_fault),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .prog_be    (prog_be),
    .init_busy  (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d; prog_be = be;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                       input logic [1:0] exp_f);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
    chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    chk({tag, "_data"},  fetch_data, exp_d);
    chk({tag, "_fault"}, {30'd0, fetch_fault}, {30'd0, exp_f});
  endtask

  // Runs the init sweep with fetch_req and prog_we held high, counting busy cycles and stray responses.
  task automatic sweep(output int n, output int stray);
    n = 0; stray = 0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    prog_we = 1'b1; prog_addr = 32'h0; prog_wdata = 32'hDEADBEEF; prog_be = 4'hF;
    do begin
      tick();
      n++;
      if (fetch_valid) stray++;
    end while (init_busy && n < 200);
    fetch_req = 1'b0;
    prog_we   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, "_data"},  fetch_data, 32'd0);
    chk({tag, "_fault"}, {30'd0, fetch_fault}, 32'd0);
    chk({tag, "_busy"},  {31'd0, init_busy}, 32'd1);
    chk({tag, "_ready"}, {31'd0, fetch_ready}, 32'd0);
  endtask

  logic [31:0] prog_words [4] = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33};

  initial begin
    int n, stray;
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_be = '0;
    repeat (3) tick();
    chk_reset_state("rst");

    // Init sweep
    reset = 1'b1;
    sweep(n, stray);
    chk("init_cycles", n, 64);
    chk("init_stray_valid", stray, 0);
    chk("init_ready", {31'd0, fetch_ready}, 32'd1);
    fetch("nop0",  32'h0,  NOP, 2'b00);
    fetch("nop7c", 32'h7C, NOP, 2'b00);
    fetch("nopfc", 32'hFC, NOP, 2'b00);
    tick();
    chk("valid_pulse", {31'd0, fetch_valid}, 32'd0);
    chk("data_hold", fetch_data, NOP);

    // Program then back-to-back fetch
    for (int i = 0; i < 4; i++) prog(32'(4 * i), prog_words[i], 4'hF);
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 32'(4 * i);
      tick();
      chk($sformatf("b2b%0d_valid", i), {31'd0, fetch_valid}, 32'd1);
      chk($sformatf("b2b%0d_data", i), fetch_data, prog_words[i]);
    end
    fetch_req = 1'b0;
    tick();
    chk("b2b_end_valid", {31'd0, fetch_valid}, 32'd0);

    // Byte enables
    prog(32'h10, 32'h019c0eb3, 4'hF);
    prog(32'h10, 32'hAABBCCDD, 4'b0101);
    fetch("be", 32'h10, 32'h01BB0EDD, 2'b00);

    // Faults; an out-of-range write would alias onto word 0 if not dropped
    fetch("mis6",    32'h6,   NOP, 2'b01);
    fetch("oor100",  32'h100, NOP, 2'b10);
    fetch("mis102",  32'h102, NOP, 2'b01);
    prog(32'h100, 32'hDEADBEEF, 4'hF);
    fetch("oorwr_w0", 32'h0, 32'h00940333, 2'b00);

    // Read-before-write collision
    prog(32'h14, 32'h01bd5f33, 4'hF);
    prog_we = 1'b1; prog_addr = 32'h14; prog_wdata = 32'h00d67fb3; prog_be = 4'hF;
    fetch_req = 1'b1; fetch_addr = 32'h14;
    tick();
    prog_we = 1'b0; fetch_req = 1'b0;
    chk("coll_valid", {31'd0, fetch_valid}, 32'd1);
    chk("coll_old", fetch_data, 32'h01bd5f33);
    fetch("coll_new", 32'h14, 32'h00d67fb3, 2'b00);

    // Reset during a fetch stream
    fetch_req = 1'b1; fetch_addr = 32'h4;
    tick();
    chk("stream_valid", {31'd0, fetch_valid}, 32'd1);
    reset = 1'b0;
    tick();
    chk_reset_state("rst_stream");
    tick();
    chk("rst_hold_valid", {31'd0, fetch_valid}, 32'd0);
    fetch_req = 1'b0;

    // Reset again at init cycle 20
    reset = 1'b1;
    repeat (20) tick();
    chk("mid_init_busy", {31'd0, init_busy}, 32'd1);
    reset = 1'b0;
    tick();
    chk_reset_state("rst_init");
    reset = 1'b1;
    sweep(n, stray);
    chk("reinit_cycles", n, 64);
    chk("reinit_stray_valid", stray, 0);
    chk("reinit_ready", {31'd0, fetch_ready}, 32'd1);
    fetch("reinit_w0",  32'h0,  NOP, 2'b00);
    fetch("reinit_w10", 32'h10, NOP, 2'b00);
    fetch("reinit_w14", 32'h14, NOP, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
